frame_rx: RTL and testbench

- Receive-side counterpart of the 40-bit time-frame generator.
- Takes the recovered serial bitstream after QPSK demodulation, IQ merge and Gardner bit sync.
- Hunts for the frame header, collects the 32 payload bits and verifies the checksum and the value ranges.
- Presents decoded hour/minute/second on parallel outputs with a one-cycle valid pulse; the display/control logic consumes them.

---
 rtl/qpsk_pkg.sv | 17 +
 rtl/frame_rx_if.sv | 17 +
 rtl/frame_check.sv | 22 ++
 rtl/frame_rx.sv | 110 +++++++++++
 tb/tb_frame_rx.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK time-frame link: frame geometry, header byte
// and the receive-side state encoding.
package qpsk_pkg;
  localparam logic [7:0] FRAME_HEADER = 8'hcc;
  localparam int         FRAME_LEN    = 40;
  localparam int         PAYLOAD_LEN  = 32;

  typedef enum logic [1:0] {HUNT, RECV, CHECK} rx_state_t;

  // Payload after the header, first field received in the top byte.
  typedef struct packed {
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
    logic [7:0] sum;
  } frame_t;
endpackage

// File: rtl/frame_rx_if.sv
// Bit-stream input and decoded-time output bundle of the frame receiver.
interface frame_rx_if;
  logic       bit_i;
  logic       bit_vld;
  logic [7:0] dec_h;
  logic [7:0] dec_m;
  logic [7:0] dec_s;
  logic       frame_vld;
  logic       frame_err;
  logic       locked;
  logic [7:0] err_cnt;

  modport master (output bit_i, bit_vld,
                  input  dec_h, dec_m, dec_s, frame_vld, frame_err, locked, err_cnt);
  modport slave  (input  bit_i, bit_vld,
                  output dec_h, dec_m, dec_s, frame_vld, frame_err, locked, err_cnt);
endinterface

// File: rtl/frame_check.sv
// Combinational frame validator: 8-bit wrap-around checksum plus optional
// h/m/s range test. Also usable as a transmit-side loopback checker.
module frame_check
  import qpsk_pkg::*;
(
  input  logic [7:0] header,
  input  logic [7:0] h,
  input  logic [7:0] m,
  input  logic [7:0] s,
  input  logic [7:0] sum,
  input  logic       range_en,
  output logic       ok
);
  logic [7:0] calc;
  logic       in_range;

  always_comb begin
    calc     = header + h + m + s;
    in_range = (h <= 8'd23) && (m <= 8'd59) && (s <= 8'd59);
    ok       = (calc == sum) && (!range_en || in_range);
  end
endmodule

// File: rtl/frame_rx.sv
// Serial time-frame receiver: hunts for the header byte, collects the 32-bit
// payload, validates it and presents h/m/s with one-cycle valid/error pulses.
module frame_rx
  import qpsk_pkg::*;
#(
  parameter logic [7:0] HEADER    = FRAME_HEADER,
  parameter bit         RANGE_CHK = 1'b1
) (
  input logic       sys_clk,
  input logic       sys_rst,
  frame_rx_if.slave rx
);
  rx_state_t   state, state_n;
  logic [7:0]  win, win_n, win_shift;
  logic [31:0] pay, pay_n;
  logic [5:0]  cnt, cnt_n;
  logic        done;
  logic        ok;
  frame_t      fr;

  logic [7:0]  dec_h, dec_m, dec_s, err_cnt;
  logic        frame_vld, frame_err, locked;

  always_comb begin
    state_n   = state;
    win_n     = win;
    pay_n     = pay;
    cnt_n     = cnt;
    done      = 1'b0;
    win_shift = {win[6:0], rx.bit_i};
    case (state)
      HUNT: if (rx.bit_vld) begin
        win_n = win_shift;
        if (win_shift == HEADER) begin
          state_n = RECV;
          pay_n   = '0;
          cnt_n   = '0;
        end
      end
      RECV: if (rx.bit_vld) begin
        pay_n = {pay[30:0], rx.bit_i};
        cnt_n = cnt + 6'd1;
        if (cnt_n == 6'(PAYLOAD_LEN)) begin
          state_n = CHECK;
          done    = 1'b1;
        end
      end
      // Window restarts empty, but a strobe landing here is still kept.
      CHECK: begin
        state_n = HUNT;
        win_n   = rx.bit_vld ? {7'd0, rx.bit_i} : 8'd0;
      end
      default: state_n = HUNT;
    endcase
  end

  // Verdict is taken on the last bit so the result pulse registers one
  // cycle after it; CHECK itself only resets the hunt window.
  assign fr = pay_n;

  frame_check u_chk (
    .header  (HEADER),
    .h       (fr.h),
    .m       (fr.m),
    .s       (fr.s),
    .sum     (fr.sum),
    .range_en(RANGE_CHK),
    .ok      (ok)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= HUNT;
      win       <= '0;
      pay       <= '0;
      cnt       <= '0;
      dec_h     <= '0;
      dec_m     <= '0;
      dec_s     <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      pay       <= pay_n;
      cnt       <= cnt_n;
      frame_vld <= done && ok;
      frame_err <= done && !ok;
      if (done && ok) begin
        dec_h  <= fr.h;
        dec_m  <= fr.m;
        dec_s  <= fr.s;
        locked <= 1'b1;
      end else if (done) begin
        locked <= 1'b0;
        if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign rx.dec_h     = dec_h;
  assign rx.dec_m     = dec_m;
  assign rx.dec_s     = dec_s;
  assign rx.frame_vld = frame_vld;
  assign rx.frame_err = frame_err;
  assign rx.locked    = locked;
  assign rx.err_cnt   = err_cnt;
endmodule

// File: tb/tb_frame_rx.sv
// Bench for frame_rx: two instances (range check on / off) fed one bit stream,
// compared every cycle against a queue-based frame model.
module tb_frame_rx;
  logic sys_clk, sys_rst;
  frame_rx_if ifa();
  frame_rx_if ifb();

  frame_rx #(.RANGE_CHK(1'b1)) u_dut1 (.sys_clk(sys_clk), .sys_rst(sys_rst), .rx(ifa));
  frame_rx #(.RANGE_CHK(1'b0)) u_dut0 (.sys_clk(sys_clk), .sys_rst(sys_rst), .rx(ifb));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_err = 0;
  int nvld [2];
  int nerrp[2];

  // model: index 0 -> RANGE_CHK=1 (ifa), index 1 -> RANGE_CHK=0 (ifb)
  bit rchk[2] = '{1'b1, 1'b0};
  bit hq[2][$];
  bit pq[2][$];
  bit in_frame[2];
  int e_h[2], e_m[2], e_s[2], e_cnt[2];
  bit e_lock[2], e_vld[2], e_err[2];

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t: got %0d expected %0d", nm, inst, $time, act, exp);
    end
  endtask

  function automatic int qbyte(input int i, input int base);
    int v = 0;
    for (int k = 0; k < 8; k++) v = v * 2 + int'(pq[i][base + k]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hq[i].delete(); pq[i].delete(); in_frame[i] = 0;
      e_h[i] = 0; e_m[i] = 0; e_s[i] = 0; e_cnt[i] = 0;
      e_lock[i] = 0; e_vld[i] = 0; e_err[i] = 0;
    end
  endtask

  task automatic model_bit(input int i, input bit b);
    int w, h, m, s, sm;
    bit ok;
    if (!in_frame[i]) begin
      hq[i].push_back(b);
      if (hq[i].size() > 8) void'(hq[i].pop_front());
      if (hq[i].size() == 8) begin
        w = 0;
        for (int k = 0; k < 8; k++) w = w * 2 + int'(hq[i][k]);
        if (w == 'hcc) begin in_frame[i] = 1; pq[i].delete(); end
      end
    end else begin
      pq[i].push_back(b);
      if (pq[i].size() == 32) begin
        h = qbyte(i, 0); m = qbyte(i, 8); s = qbyte(i, 16); sm = qbyte(i, 24);
        ok = ((204 + h + m + s) % 256 == sm) && (!rchk[i] || (h < 24 && m < 60 && s < 60));
        if (ok) begin
          e_vld[i] = 1; e_lock[i] = 1; e_h[i] = h; e_m[i] = m; e_s[i] = s;
        end else begin
          e_err[i] = 1; e_lock[i] = 0;
          if (e_cnt[i] < 255) e_cnt[i]++;
        end
        in_frame[i] = 0;
        hq[i].delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic b);
    @(negedge sys_clk); #1;
    ifa.bit_vld = v; ifa.bit_i = b;
    ifb.bit_vld = v; ifb.bit_i = b;
    for (int i = 0; i < 2; i++) begin
      e_vld[i] = 0; e_err[i] = 0;
      if (v) model_bit(i, b);
    end
  endtask

  task automatic send_frame(input logic [39:0] w, input int gap);
    for (int k = 39; k >= 0; k--) begin
      step(1'b1, w[k]);
      repeat (gap - 1) step(1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk); #1;
    sys_rst = 1'b1;
    ifa.bit_vld = 0; ifb.bit_vld = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    #1 sys_rst = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    chk("dec_h",     0, int'(ifa.dec_h),     e_h[0]);
    chk("dec_m",     0, int'(ifa.dec_m),     e_m[0]);
    chk("dec_s",     0, int'(ifa.dec_s),     e_s[0]);
    chk("frame_vld", 0, int'(ifa.frame_vld), int'(e_vld[0]));
    chk("frame_err", 0, int'(ifa.frame_err), int'(e_err[0]));
    chk("locked",    0, int'(ifa.locked),    int'(e_lock[0]));
    chk("err_cnt",   0, int'(ifa.err_cnt),   e_cnt[0]);
    chk("dec_h",     1, int'(ifb.dec_h),     e_h[1]);
    chk("dec_m",     1, int'(ifb.dec_m),     e_m[1]);
    chk("dec_s",     1, int'(ifb.dec_s),     e_s[1]);
    chk("frame_vld", 1, int'(ifb.frame_vld), int'(e_vld[1]));
    chk("frame_err", 1, int'(ifb.frame_err), int'(e_err[1]));
    chk("locked",    1, int'(ifb.locked),    int'(e_lock[1]));
    chk("err_cnt",   1, int'(ifb.err_cnt),   e_cnt[1]);
    if (ifa.frame_vld) nvld[0]++;
    if (ifb.frame_vld) nvld[1]++;
    if (ifa.frame_err) nerrp[0]++;
    if (ifb.frame_err) nerrp[1]++;
  end

  localparam logic [39:0] F_GOOD = 40'hcc_0c_22_38_32;
  localparam logic [39:0] F_BAD  = 40'hcc_0c_22_38_33;
  localparam logic [39:0] F_H24  = 40'hcc_18_00_00_e4;

  initial begin
    logic [12:0] noise;
    noise = 13'h1555;
    nvld = '{0, 0}; nerrp = '{0, 0};
    sys_rst = 1'b1;
    ifa.bit_vld = 0; ifa.bit_i = 0; ifb.bit_vld = 0; ifb.bit_i = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    #1 sys_rst = 1'b0;

    // clean frame, sparse strobe
    send_frame(F_GOOD, 4);
    repeat (3) step(1'b0, 1'b0);
    chk("lit_dec_h", 0, int'(ifa.dec_h), 12);
    chk("lit_dec_m", 0, int'(ifa.dec_m), 34);
    chk("lit_dec_s", 0, int'(ifa.dec_s), 56);
    chk("lit_locked", 0, int'(ifa.locked), 1);
    chk("lit_nvld", 0, nvld[0], 1);

    // bad checksum
    send_frame(F_BAD, 4);
    repeat (3) step(1'b0, 1'b0);
    chk("lit_err_cnt", 0, int'(ifa.err_cnt), 1);
    chk("lit_locked", 0, int'(ifa.locked), 0);
    chk("lit_dec_h", 0, int'(ifa.dec_h), 12);

    // hour out of range, checksum fine
    send_frame(F_H24, 2);
    repeat (3) step(1'b0, 1'b0);
    chk("lit_err_cnt", 0, int'(ifa.err_cnt), 2);
    chk("lit_dec_h", 1, int'(ifb.dec_h), 24);
    chk("lit_locked", 1, int'(ifb.locked), 1);

    // noise then back-to-back good frames; second frame's first bit lands in CHECK
    for (int k = 12; k >= 0; k--) step(1'b1, noise[k]);
    send_frame(F_GOOD, 1);
    send_frame(F_GOOD, 1);
    repeat (3) step(1'b0, 1'b0);
    chk("lit_nvld", 0, nvld[0], 3);
    chk("lit_dec_h", 1, int'(ifb.dec_h), 12);

    // reset mid-frame
    for (int k = 39; k >= 20; k--) step(1'b1, F_GOOD[k]);
    do_reset();
    chk("lit_rst_cnt", 0, int'(ifa.err_cnt), 0);
    chk("lit_rst_h", 0, int'(ifa.dec_h), 0);
    send_frame(F_GOOD, 1);
    repeat (2) step(1'b0, 1'b0);
    chk("lit_dec_s", 0, int'(ifa.dec_s), 56);

    // saturation
    nerrp = '{0, 0};
    repeat (260) send_frame(F_BAD, 1);
    repeat (3) step(1'b0, 1'b0);
    chk("lit_sat", 0, int'(ifa.err_cnt), 255);
    chk("lit_sat", 1, int'(ifb.err_cnt), 255);
    chk("lit_nerrp", 0, nerrp[0], 260);
    chk("lit_nvld", 0, nvld[0], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
